bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the single-digit BCD adder stage. It converts a binary operand into packed BCD digits, which are then fed digit-by-digit into the BCD adder. A start/busy/done handshake lets a controller launch one conversion at a time.

## Interface
Parameters:
- BIN_W, 8: width of the binary input in bits; legal range 1..16.
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS ≥ 2^BIN_W; this is checked at elaboration, which fails if the constraint is violated.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a conversion; sampled only in IDLE.
- bin_in  in  BIN_W  binary operand; sampled on the edge that accepts start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  single-cycle pulse when bcd_out is updated.
- bcd_out  out  4*DIGITS  packed BCD result; bits [3:0] are units, [7:4] tens, and so on.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE:
  - If start=1 at a rising edge: load shift register with bin_in, clear BCD scratch to 0, set counter to BIN_W, assert busy, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  - For every scratch digit ≥5, add 3 (4-bit result, no carry out of the digit).
  - Shift the corrected scratch and the shift register left by 1 as one concatenated vector. The binary MSB enters the units digit LSB.
  - Decrement the counter.
- On the edge where the counter goes 1→0:
  - Write the post-shift scratch to bcd_out.
  - Pulse done, deassert busy, return to IDLE.
- Scratch digits never exceed 9 after a shift, given legal inputs.
- bcd_out holds its last result until the next completion. It never shows intermediate values.
- start while busy=1 is ignored; no queueing, and bin_in is not re-sampled.
- bin_in changes during a conversion have no effect.
- rst asserted at any time, including mid-conversion:
  - State goes to IDLE; busy=0, done=0, bcd_out=0, counter and scratch cleared.
  - The aborted conversion produces no done pulse.

## Timing
- Reset values: busy=0, done=0, bcd_out=0, state=IDLE.
- Let start be accepted on edge E:
  - busy=1 from edge E through edge E+BIN_W.
  - bcd_out is valid and done=1 in the cycle after edge E+BIN_W.
  - done=0 again after edge E+BIN_W+1.
- Latency from accepted start to done is BIN_W cycles (8 for the defaults).
- Throughput: start asserted in the same cycle that done is high is accepted, because the FSM is in IDLE. Back-to-back conversions therefore run every BIN_W+1 cycles.
- Held start is re-accepted on every IDLE cycle. A controller wanting a single conversion drops start after the accept edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package contents:
  - State encoding constants IDLE=1'b0, SHIFT=1'b1.
  - BCD digit width constant (4).
  - Correction threshold (5) and correction constant (3).
- Sub-module bcd_add3: combinational 4-bit digit corrector (d≥5 ? d+3 : d). It is instantiated DIGITS times by generate loop.
- Counter width: $clog2(BIN_W+1).

## Test plan
- Zero and max values (defaults): reset, then bin_in=0 with start pulse → done after 8 cycles, bcd_out=12'h000. Then bin_in=255 → bcd_out=12'h255, busy high exactly 8 cycles.
- Digit boundaries: bin_in=9, 10, 99, 100, 199 → bcd_out=12'h009, 12'h010, 12'h099, 12'h100, 12'h199. Each gets exactly one done pulse.
- Start while busy: start bin_in=123, then pulse start with bin_in=45 at cycle 3 → result 12'h123, no second done. bin_in changes mid-conversion also have no effect.
- Reset mid-operation: start bin_in=200, assert rst at cycle 4 → busy=0, bcd_out=0, no done. A following start with bin_in=57 → bcd_out=12'h057.
- Back-to-back: hold start high with bin_in=17 then 250 (bin_in changed on the done cycle) → done pulses 9 cycles apart, results 12'h017 then 12'h250.
- Exhaustive sweep: all 256 inputs compared against a reference model of digit division (n%10, n/10%10, n/100). The bench also checks no scratch digit >9 ever reaches bcd_out.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned ADD3_THRESH = 5;
  localparam int unsigned ADD3_CORR   = 3;

  // True when DIGITS decimal digits can represent every BIN_W-bit value.
  function automatic bit digits_cover(input int unsigned bin_w, input int unsigned digits);
    longint unsigned p10;
    p10 = 64'd1;
    for (int unsigned i = 0; i < digits; i++) p10 = p10 * 64'd10;
    return p10 >= (64'd1 << bin_w);
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and data bus between a controller and the converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (output start, bin_in, input busy, done, bcd_out);
  modport slave  (input start, bin_in, output busy, done, bcd_out);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more.
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q_c
);
  always_comb q_c = (d >= DIGIT_W'(ADD3_THRESH)) ? d + DIGIT_W'(ADD3_CORR) : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input logic             clk,
  input logic             rst,
  bin_to_bcd_seq_if.slave bus
);
  localparam int unsigned SCR_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned CAT_W = SCR_W + BIN_W;

  if (BIN_W < 1 || BIN_W > 16 || !digits_cover(BIN_W, DIGITS)) begin : g_bad_params
    $error("bin_to_bcd_seq: illegal BIN_W/DIGITS combination");
  end

  state_t             state;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   corrected;
  logic [BIN_W-1:0]   shreg;
  logic [CNT_W-1:0]   cnt;
  logic [CAT_W-1:0]   shifted_c;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .d   (scratch[g*DIGIT_W +: DIGIT_W]),
      .q_c (corrected[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Corrected scratch and binary operand shift as one vector; binary MSB enters units LSB.
  assign shifted_c = {corrected, shreg} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      scratch     <= '0;
      shreg       <= '0;
      cnt         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bcd_out <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg    <= bus.bin_in;
            scratch  <= '0;
            cnt      <= CNT_W'(BIN_W);
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted_c[CAT_W-1 -: SCR_W];
          shreg   <= shifted_c[BIN_W-1:0];
          cnt     <= cnt - CNT_W'(1);
          // Last step: publish the post-shift scratch so intermediates never appear.
          if (cnt == CNT_W'(1)) begin
            bus.bcd_out <= shifted_c[CAT_W-1 -: SCR_W];
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, corner sequences and a full sweep.
module tb_bin_to_bcd_seq;
  localparam int unsigned BIN_W  = 8;
  localparam int unsigned DIGITS = 3;

  logic clk;
  logic rst;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [11:0] sb[$];

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_cnt++;
      for (int i = 0; i < 3; i++)
        check("digit_le_9", 32'(bus.bcd_out[i*4 +: 4] <= 4'd9), 32'd1);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got bcd_out=%0h, required no done", bus.bcd_out);
      end else begin
        check("bcd_out", 32'(bus.bcd_out), 32'(sb.pop_front()));
      end
    end
  end

  // One conversion with latency and busy-width checks; bin_in scrambled after accept.
  task automatic run_one(input logic [7:0] bin, input logic [11:0] exp, input bit timing);
    int cycles;
    int busy_cnt;
    @(negedge clk);
    bus.bin_in = bin;
    bus.start  = 1'b1;
    sb.push_back(exp);
    exp_done++;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.bin_in = 8'($urandom);
    cycles = 0;
    busy_cnt = 0;
    while (!bus.done && cycles < 40) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (timing || cycles >= 40) begin
      check("latency", 32'(cycles), 32'(BIN_W));
      check("busy_width", 32'(busy_cnt), 32'(BIN_W));
    end
  endtask

  initial begin
    vec_t vecs[7];
    int cycles;
    vecs[0] = '{8'd0,   12'h000};
    vecs[1] = '{8'd255, 12'h255};
    vecs[2] = '{8'd9,   12'h009};
    vecs[3] = '{8'd10,  12'h010};
    vecs[4] = '{8'd99,  12'h099};
    vecs[5] = '{8'd100, 12'h100};
    vecs[6] = '{8'd199, 12'h199};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.bin_in = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_bcd", 32'(bus.bcd_out), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_one(vecs[i].bin, vecs[i].exp, 1'b1);

    // Start while busy is ignored; the single done carries the first operand.
    @(negedge clk);
    bus.bin_in = 8'd123;
    bus.start  = 1'b1;
    sb.push_back(12'h123);
    exp_done++;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = 8'd77;
    repeat (2) @(negedge clk);
    bus.bin_in = 8'd45;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = 8'd200;
    repeat (14) @(negedge clk);
    check("busy_after_ignored_start", 32'(bus.busy), 32'd0);

    // Reset mid-conversion: outputs cleared, no done for the aborted operand.
    @(negedge clk);
    bus.bin_in = 8'd200;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_bcd", 32'(bus.bcd_out), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_idle", 32'(bus.busy), 32'd0);
    run_one(8'd57, 12'h057, 1'b1);

    // Back-to-back with start held: second accept on the done cycle, 9 cycles apart.
    @(negedge clk);
    bus.bin_in = 8'd17;
    bus.start  = 1'b1;
    sb.push_back(12'h017);
    exp_done++;
    @(posedge clk);
    repeat (BIN_W) @(posedge clk);
    @(negedge clk);
    check("b2b_first_done", 32'(bus.done), 32'd1);
    bus.bin_in = 8'd250;
    sb.push_back(12'h250);
    exp_done++;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("b2b_done_gap", 32'(cycles + 1), 32'(BIN_W + 1));

    // Exhaustive sweep against a digit-division model.
    for (int n = 0; n < 256; n++) run_one(8'(n), ref_bcd(n), 1'b0);

    repeat (12) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(exp_done));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
